// File: rtl/epb_master_ctrl.sv
// EPB initiator: turns single-word local requests into EPB bus cycles and
// completes them on responder epb_rdy or a strobe timeout.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | addr/be/r_w_n (and write data) stable, cs_n high
// STROBE | cs_n low, waiting for epb_rdy or timeout
// HOLD   | cs_n high, addr/be/r_w_n/write data held
// RESP   | one-cycle rsp_valid pulse
module epb_master_ctrl #(
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic        epb_clk,
  input  logic        epb_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rnw,
  input  logic [22:0] req_addr,
  input  logic [5:0]  req_addr_gp,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        epb_cs_n,
  output logic        epb_oe_n,
  output logic        epb_r_w_n,
  output logic [1:0]  epb_be_n,
  output logic [22:0] epb_addr,
  output logic [5:0]  epb_addr_gp,
  output logic [15:0] epb_data_out,
  output logic        epb_data_oe_n,
  input  logic [15:0] epb_data_in,
  input  logic        epb_rdy
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int PMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int PW = $clog2(PMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase_cnt, phase_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [15:0]   rd_cap;
  logic          tmo_q;
  logic          accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;

  always_ff @(posedge epb_clk or negedge epb_rst_n) begin
    if (!epb_rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      wait_cnt  <= wait_nxt;
    end
  end

  // Setup/hold phases use a down-counter; the strobe wait counts up from 1.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = SETUP;
          phase_nxt = PW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (phase_cnt == '0) begin
          state_nxt = STROBE;
          wait_nxt  = WW'(1);
        end else begin
          phase_nxt = phase_cnt - PW'(1);
        end
      end
      STROBE: begin
        if (epb_rdy || (wait_cnt == WW'(TIMEOUT))) begin
          state_nxt = HOLD;
          phase_nxt = PW'(HOLD_CYC - 1);
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      HOLD: begin
        if (phase_cnt == '0) state_nxt = RESP;
        else phase_nxt = phase_cnt - PW'(1);
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge epb_clk or negedge epb_rst_n) begin
    if (!epb_rst_n) begin
      epb_cs_n      <= 1'b1;
      epb_oe_n      <= 1'b1;
      epb_r_w_n     <= 1'b1;
      epb_be_n      <= 2'b11;
      epb_addr      <= '0;
      epb_addr_gp   <= '0;
      epb_data_out  <= '0;
      epb_data_oe_n <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_timeout   <= 1'b0;
      rd_cap        <= '0;
      tmo_q         <= 1'b0;
    end else begin
      epb_cs_n  <= (state_nxt != STROBE);
      epb_oe_n  <= !((state_nxt == STROBE) && epb_r_w_n);
      rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        epb_addr      <= req_addr;
        epb_addr_gp   <= req_addr_gp;
        epb_be_n      <= ~req_be;
        epb_r_w_n     <= req_rnw;
        epb_data_oe_n <= req_rnw;
        if (!req_rnw) epb_data_out <= req_wdata;
      end else if ((state == HOLD) && (state_nxt == RESP)) begin
        epb_be_n      <= 2'b11;
        epb_r_w_n     <= 1'b1;
        epb_data_oe_n <= 1'b1;
      end
      // Ready wins over timeout when both land in the same strobe cycle.
      if ((state == STROBE) && (state_nxt == HOLD)) begin
        rd_cap <= (epb_rdy && epb_r_w_n) ? epb_data_in : 16'h0000;
        tmo_q  <= !epb_rdy;
      end
      if (state_nxt == RESP) begin
        rsp_rdata   <= rd_cap;
        rsp_timeout <= tmo_q;
      end
    end
  end

endmodule
